hash_se_initiator: RTL and testbench
====================================

# hash_se_initiator

Request-side controller for a 2-way MAC hash bucket. It takes one frame descriptor at a time from the frame-processing pipeline and computes the 10-bit bucket hash. It then issues a source-learn request followed by a destination-lookup request over the se_* handshake, and returns the egress portmap. It also runs the aging timer that drives the bucket's aging_req/aging_ack sweep.

## Interface
- AGING_PERIOD, 32'd1_000_000: idle cycles between the end of one aging sweep and the next aging_req.
- TIMEOUT, 5'd16: cycles to wait for se_ack/se_nak before abandoning a request.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ft_req  in  1  descriptor valid; level, held by upstream until ft_ack
- ft_da  in  48  destination MAC
- ft_sa  in  48  source MAC
- ft_port  in  4  ingress port number
- ft_ack  out  1  one-cycle pulse; ft_result valid in the same cycle
- ft_result  out  16  egress portmap; ingress bit always cleared
- se_req  out  1  request to bucket; level
- se_source  out  1  1 = learn SA, 0 = lookup DA
- se_mac  out  48  MAC under request
- se_hash  out  10  bucket index
- se_portmap  out  16  one-hot ingress port
- se_ack  in  1  bucket success pulse
- se_nak  in  1  bucket fail pulse (learn: bucket full; lookup: miss)
- se_result  in  16  lookup portmap; equals ~se_portmap on a miss
- aging_req  out  1  aging sweep request; level
- aging_ack  in  1  sweep-complete pulse

## Operation
- Hash: h(m) = m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b0, m[47:40]}.
- src_oh = 16'b1 << ft_port.
- FSM states: IDLE, LEARN, GAP, LOOK, DONE.
- IDLE: if ft_req is high, latch da, sa, and src_oh.
  - If sa[40] is 0 (unicast): drive se_source=1, se_mac=sa, se_hash=h(sa), se_portmap=src_oh, se_req=1, and go to LEARN.
  - Otherwise skip learning and go to GAP.
- LEARN: wait for se_ack, se_nak, or timeout. On any of these, se_req goes to 0 and the FSM goes to GAP. The learn outcome is discarded.
- GAP: exactly one cycle with se_req=0.
  - If da[40] is 1 (multicast/broadcast): result = ~src_oh, go to DONE, no lookup issued.
  - Otherwise drive se_source=0, se_mac=da, se_hash=h(da), se_req=1, and go to LOOK.
- LOOK: wait for a response.
  - se_ack: result = se_result & ~src_oh.
  - se_nak or timeout: result = ~src_oh (flood).
  - se_req goes to 0 and the FSM goes to DONE.
- DONE: drive ft_ack=1 and ft_result=result, then return to IDLE. ft_req is not re-sampled until IDLE.
- Timeout counter:
  - Cleared when se_req rises.
  - Increments each cycle in LEARN/LOOK.
  - Fires when count == TIMEOUT-1. This covers the bucket's known no-response case, where both ways hit on learn.
- Aging:
  - The 32-bit counter runs only while aging_req is 0.
  - When the counter reaches AGING_PERIOD-1, aging_req goes to 1 and the counter clears.
  - aging_req stays at 1 until aging_ack is sampled, then goes to 0 the next cycle.
  - Aging is independent of the request FSM. The bucket gives se_req priority, so se_req and aging_req may both be high.

## Timing
- Reset values: all outputs 0, FSM in IDLE, both counters 0.
- All outputs are registered.
- se_source, se_mac, se_hash, and se_portmap are stable for the whole time se_req is high.
- se_req falls on the edge after the cycle where se_ack, se_nak, or the timeout is seen. This guarantees the bucket's return-to-idle cycle sees se_req=0, so there are no duplicate requests.
- ft_req sampled at T0 → se_req high at T1.
- A response at Tr → se_req low at Tr+1 → lookup se_req high at Tr+2, or ft_ack at Tr+2 if no lookup is issued.
- A lookup response at Tl → ft_ack at Tl+1.
- se_ack and se_nak in the same cycle: treat as se_ack.
- A response outside LEARN/LOOK is ignored.
- A response in the timeout cycle: the response wins.
- ft_req dropping mid-operation: the operation completes and ft_ack still pulses.
- Async reset mid-operation: immediate return to reset values, no ft_ack. An in-flight bucket response arriving afterwards is ignored.
- aging_ack while aging_req is 0: ignored.

## Test plan
- Unicast learn and hit:
  - Stimulus: ft_sa=0x0000_1111_2222, ft_da=0x0000_3333_4444, ft_port=2. Bucket acks the learn, then acks the lookup with se_result=0x0021.
  - Required: se_hash on learn = h(sa); ft_result=0x0021 & ~0x0004 = 0x0021; one-cycle se_req gap between the two requests.
- Lookup miss:
  - Stimulus: bucket naks the lookup with se_result=0xFFF7, ft_port=3.
  - Required: ft_result=0xFFF7.
- Broadcast DA:
  - Stimulus: ft_da=0xFFFF_FFFF_FFFF, ft_port=0.
  - Required: only one se_req (learn); ft_result=0xFFFE.
- Learn timeout:
  - Stimulus: bucket never responds to the learn, TIMEOUT=16.
  - Required: se_req drops after 16 cycles; lookup still issued; ft_ack follows.
- Aging:
  - Stimulus: AGING_PERIOD=100, aging_ack returned 50 cycles after aging_req rises, with frames issued concurrently.
  - Required: aging_req rises at cycle 100 after reset and falls the cycle after aging_ack. The next rise is 100 cycles later.
- Reset mid-LOOK:
  - Stimulus: assert rstn=0 during LOOK.
  - Required: all outputs are 0 immediately; a late se_ack produces no ft_ack.

Source files
------------

// File: rtl/hash_se_initiator.sv
// hash_se_initiator: turns one frame descriptor into a source-learn and a destination-lookup
// request to a 2-way MAC hash bucket, and paces the bucket's periodic aging sweeps.
module hash_se_initiator #(
  parameter logic [31:0] AGING_PERIOD = 32'd1_000_000,
  parameter logic [4:0]  TIMEOUT      = 5'd16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ft_req,
  input  logic [47:0] ft_da,
  input  logic [47:0] ft_sa,
  input  logic [3:0]  ft_port,
  output logic        ft_ack,
  output logic [15:0] ft_result,
  output logic        se_req,
  output logic        se_source,
  output logic [47:0] se_mac,
  output logic [9:0]  se_hash,
  output logic [15:0] se_portmap,
  input  logic        se_ack,
  input  logic        se_nak,
  input  logic [15:0] se_result,
  output logic        aging_req,
  input  logic        aging_ack
);

  typedef enum logic [2:0] {IDLE, LEARN, GAP, LOOK, DONE} state_t;

  localparam logic [4:0]  TMO_LAST = TIMEOUT - 5'd1;
  localparam logic [31:0] AGE_LAST = AGING_PERIOD - 32'd1;

  state_t      state, state_next;
  logic [47:0] da, da_next;
  logic [15:0] src_oh, src_oh_next;
  logic        ft_ack_next;
  logic [15:0] ft_result_next;
  logic        se_req_next;
  logic        se_source_next;
  logic [47:0] se_mac_next;
  logic [9:0]  se_hash_next;
  logic [15:0] se_portmap_next;
  logic [4:0]  tmo_cnt;
  logic        tmo;
  logic [31:0] age_cnt;

  function automatic logic [9:0] bucket_hash(input logic [47:0] m);
    return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b00, m[47:40]};
  endfunction

  assign tmo = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      da         <= '0;
      src_oh     <= '0;
      ft_ack     <= 1'b0;
      ft_result  <= '0;
      se_req     <= 1'b0;
      se_source  <= 1'b0;
      se_mac     <= '0;
      se_hash    <= '0;
      se_portmap <= '0;
    end else begin
      state      <= state_next;
      da         <= da_next;
      src_oh     <= src_oh_next;
      ft_ack     <= ft_ack_next;
      ft_result  <= ft_result_next;
      se_req     <= se_req_next;
      se_source  <= se_source_next;
      se_mac     <= se_mac_next;
      se_hash    <= se_hash_next;
      se_portmap <= se_portmap_next;
    end
  end

  // Request fields only change while se_req is low, so the bucket always sees them stable.
  always_comb begin
    state_next      = state;
    da_next         = da;
    src_oh_next     = src_oh;
    ft_ack_next     = 1'b0;
    ft_result_next  = ft_result;
    se_req_next     = se_req;
    se_source_next  = se_source;
    se_mac_next     = se_mac;
    se_hash_next    = se_hash;
    se_portmap_next = se_portmap;

    case (state)
      IDLE: begin
        if (ft_req) begin
          da_next     = ft_da;
          src_oh_next = 16'b1 << ft_port;
          if (!ft_sa[40]) begin
            se_source_next  = 1'b1;
            se_mac_next     = ft_sa;
            se_hash_next    = bucket_hash(ft_sa);
            se_portmap_next = 16'b1 << ft_port;
            se_req_next     = 1'b1;
            state_next      = LEARN;
          end else begin
            state_next = GAP;
          end
        end
      end
      LEARN: begin
        if (se_ack || se_nak || tmo) begin
          se_req_next = 1'b0;
          state_next  = GAP;
        end
      end
      GAP: begin
        if (da[40]) begin
          ft_result_next = ~src_oh;
          ft_ack_next    = 1'b1;
          state_next     = DONE;
        end else begin
          se_source_next  = 1'b0;
          se_mac_next     = da;
          se_hash_next    = bucket_hash(da);
          se_portmap_next = src_oh;
          se_req_next     = 1'b1;
          state_next      = LOOK;
        end
      end
      // A response that coincides with the timeout still takes precedence over flooding.
      LOOK: begin
        if (se_ack) begin
          ft_result_next = se_result & ~src_oh;
          ft_ack_next    = 1'b1;
          se_req_next    = 1'b0;
          state_next     = DONE;
        end else if (se_nak || tmo) begin
          ft_result_next = ~src_oh;
          ft_ack_next    = 1'b1;
          se_req_next    = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (se_req_next && !se_req) begin
      tmo_cnt <= '0;
    end else if (state == LEARN || state == LOOK) begin
      tmo_cnt <= tmo_cnt + 5'd1;
    end
  end

  // The aging period is measured from the end of one sweep to the next request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age_cnt   <= '0;
      aging_req <= 1'b0;
    end else if (aging_req) begin
      if (aging_ack) begin
        aging_req <= 1'b0;
      end
    end else if (age_cnt == AGE_LAST) begin
      aging_req <= 1'b1;
      age_cnt   <= '0;
    end else begin
      age_cnt <= age_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hash_se_initiator.sv
// tb_hash_se_initiator: directed bench acting as frame pipeline and hash bucket for
// hash_se_initiator, with hand-computed hashes and portmaps.
module tb_hash_se_initiator;

  logic        clk;
  logic        rstn;
  logic        ft_req;
  logic [47:0] ft_da;
  logic [47:0] ft_sa;
  logic [3:0]  ft_port;
  logic        ft_ack;
  logic [15:0] ft_result;
  logic        se_req;
  logic        se_source;
  logic [47:0] se_mac;
  logic [9:0]  se_hash;
  logic [15:0] se_portmap;
  logic        se_ack;
  logic        se_nak;
  logic [15:0] se_result;
  logic        aging_req;
  logic        aging_ack;

  int n_checks = 0;
  int n_errors = 0;
  int edges;

  hash_se_initiator #(
    .AGING_PERIOD(32'd100),
    .TIMEOUT(5'd16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ft_req(ft_req),
    .ft_da(ft_da),
    .ft_sa(ft_sa),
    .ft_port(ft_port),
    .ft_ack(ft_ack),
    .ft_result(ft_result),
    .se_req(se_req),
    .se_source(se_source),
    .se_mac(se_mac),
    .se_hash(se_hash),
    .se_portmap(se_portmap),
    .se_ack(se_ack),
    .se_nak(se_nak),
    .se_result(se_result),
    .aging_req(aging_req),
    .aging_ack(aging_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; used to time the aging requests.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic start_frame(input logic [47:0] da, input logic [47:0] sa, input logic [3:0] port);
    ft_da   = da;
    ft_sa   = sa;
    ft_port = port;
    ft_req  = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic ack, input logic nak, input logic [15:0] result);
    se_ack    = ack;
    se_nak    = nak;
    se_result = result;
    @(negedge clk);
    se_ack    = 1'b0;
    se_nak    = 1'b0;
    se_result = '0;
  endtask

  task automatic check_req(input string tag, input logic src, input logic [47:0] mac,
                           input logic [9:0] hash, input logic [15:0] pm);
    check_output({tag, "_req"},     64'(se_req),     64'h1);
    check_output({tag, "_source"},  64'(se_source),  64'(src));
    check_output({tag, "_mac"},     64'(se_mac),     64'(mac));
    check_output({tag, "_hash"},    64'(se_hash),    64'(hash));
    check_output({tag, "_portmap"}, 64'(se_portmap), 64'(pm));
  endtask

  task automatic check_done(input string tag, input logic [15:0] result);
    check_output({tag, "_ack"},    64'(ft_ack),    64'h1);
    check_output({tag, "_result"}, 64'(ft_result), 64'(result));
    check_output({tag, "_se_idle"}, 64'(se_req),   64'h0);
    ft_req = 1'b0;
    @(negedge clk);
    check_output({tag, "_ack_pulse"}, 64'(ft_ack), 64'h0);
  endtask

  initial begin
    int n;
    int rise_edge;
    int ack_edge;
    logic seen;

    rstn      = 1'b0;
    ft_req    = 1'b0;
    ft_da     = '0;
    ft_sa     = '0;
    ft_port   = '0;
    se_ack    = 1'b0;
    se_nak    = 1'b0;
    se_result = '0;
    aging_ack = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_ft_ack",    64'(ft_ack),     64'h0);
    check_output("rst_ft_result", 64'(ft_result),  64'h0);
    check_output("rst_se_req",    64'(se_req),     64'h0);
    check_output("rst_se_mac",    64'(se_mac),     64'h0);
    check_output("rst_se_hash",   64'(se_hash),    64'h0);
    check_output("rst_aging_req", 64'(aging_req),  64'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Unicast learn acked, lookup hit.
    start_frame(48'h0000_3333_4444, 48'h0000_1111_2222, 4'd2);
    check_req("t1_learn", 1'b1, 48'h0000_1111_2222, 10'h37B, 16'h0004);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_output("t1_gap", 64'(se_req), 64'h0);
    @(negedge clk);
    check_req("t1_look", 1'b0, 48'h0000_3333_4444, 10'h3A6, 16'h0004);
    apply_stimulus(1'b1, 1'b0, 16'h0021);
    check_done("t1", 16'h0021);

    // Learn nak (bucket full), lookup miss.
    start_frame(48'h0000_0000_0400, 48'h0000_0000_0005, 4'd3);
    check_req("t2_learn", 1'b1, 48'h0000_0000_0005, 10'h005, 16'h0008);
    apply_stimulus(1'b0, 1'b1, 16'h0000);
    check_output("t2_gap", 64'(se_req), 64'h0);
    @(negedge clk);
    check_req("t2_look", 1'b0, 48'h0000_0000_0400, 10'h001, 16'h0008);
    apply_stimulus(1'b0, 1'b1, 16'hFFF7);
    check_done("t2", 16'hFFF7);

    // Simultaneous ack and nak on lookup counts as a hit.
    start_frame(48'h0000_0000_0C00, 48'h0000_0000_0003, 4'd4);
    check_req("t3_learn", 1'b1, 48'h0000_0000_0003, 10'h003, 16'h0010);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check_req("t3_look", 1'b0, 48'h0000_0000_0C00, 10'h003, 16'h0010);
    apply_stimulus(1'b1, 1'b1, 16'h00F0);
    check_done("t3", 16'h00E0);

    // Broadcast DA: learn only, then flood.
    start_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 4'd0);
    check_req("t4_learn", 1'b1, 48'h0000_0000_0001, 10'h001, 16'h0001);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_output("t4_gap", 64'(se_req), 64'h0);
    @(negedge clk);
    check_done("t4", 16'hFFFE);

    // Multicast SA: no learn, gap cycle, then lookup.
    start_frame(48'h0000_3333_4444, 48'h0100_0000_0000, 4'd1);
    check_output("t5_no_learn", 64'(se_req), 64'h0);
    @(negedge clk);
    check_req("t5_look", 1'b0, 48'h0000_3333_4444, 10'h3A6, 16'h0002);
    apply_stimulus(1'b1, 1'b0, 16'h00FF);
    check_done("t5", 16'h00FD);

    // Bucket silent on both requests: two timeouts, then flood.
    start_frame(48'h0000_0000_0800, 48'h0000_0000_0002, 4'd5);
    check_req("t6_learn", 1'b1, 48'h0000_0000_0002, 10'h002, 16'h0020);
    n = 0;
    while (se_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_output("t6_learn_tmo_len", 64'(n), 64'd16);
    @(negedge clk);
    check_req("t6_look", 1'b0, 48'h0000_0000_0800, 10'h002, 16'h0020);
    n = 0;
    while (se_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_output("t6_look_tmo_len", 64'(n), 64'd16);
    check_done("t6", 16'hFFDF);

    // Aging request after 100 cycles from reset release.
    check_output("age_low_before", 64'(aging_req), 64'h0);
    n = 0;
    while (!aging_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    rise_edge = edges;
    check_output("age_first_rise", 64'(rise_edge), 64'd100);

    // Frame during the sweep; lookup answered in its timeout cycle.
    start_frame(48'h0000_0000_0400, 48'h0100_0000_0000, 4'd6);
    check_output("t7_no_learn", 64'(se_req), 64'h0);
    @(negedge clk);
    check_req("t7_look", 1'b0, 48'h0000_0000_0400, 10'h001, 16'h0040);
    check_output("t7_age_overlap", 64'(aging_req), 64'h1);
    repeat (15) @(negedge clk);
    check_output("t7_last_cycle", 64'(se_req), 64'h1);
    apply_stimulus(1'b1, 1'b0, 16'h0F40);
    check_done("t7", 16'h0F00);

    while (edges < rise_edge + 49) @(negedge clk);
    check_output("age_held", 64'(aging_req), 64'h1);
    aging_ack = 1'b1;
    @(negedge clk);
    aging_ack = 1'b0;
    ack_edge  = edges;
    check_output("age_fall", 64'(aging_req), 64'h0);
    n = 0;
    while (!aging_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_output("age_second_rise", 64'(edges), 64'(ack_edge + 100));

    // Reset during LOOK, then a stale bucket ack.
    start_frame(48'h0000_3333_4444, 48'h0100_0000_0000, 4'd7);
    @(negedge clk);
    check_req("t8_look", 1'b0, 48'h0000_3333_4444, 10'h3A6, 16'h0080);
    rstn = 1'b0;
    #1;
    check_output("t8_rst_se_req",     64'(se_req),     64'h0);
    check_output("t8_rst_se_mac",     64'(se_mac),     64'h0);
    check_output("t8_rst_se_hash",    64'(se_hash),    64'h0);
    check_output("t8_rst_se_portmap", 64'(se_portmap), 64'h0);
    check_output("t8_rst_ft_result",  64'(ft_result),  64'h0);
    check_output("t8_rst_aging_req",  64'(aging_req),  64'h0);
    @(negedge clk);
    ft_req = 1'b0;
    rstn   = 1'b1;
    seen   = 1'b0;
    apply_stimulus(1'b1, 1'b0, 16'hFFFF);
    repeat (5) begin
      if (ft_ack || se_req) seen = 1'b1;
      @(negedge clk);
    end
    check_output("t8_no_late_ack", 64'(seen), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
